// File: rtl/int_adder_tree_stream.sv
// Streaming integer adder: a registered binary tree sums NUM_IN_WORDS words per beat, then an
// accumulator stage adds up to ACC_BEATS tree sums into one output group.
module int_adder_tree_stream #(
  parameter int unsigned NUM_IN_WORDS     = 4,
  parameter int unsigned BITS_PER_IN_WORD = 8,
  parameter int unsigned ACC_BEATS        = 4,
  parameter int unsigned SIGN_EXT         = 1,
  parameter int unsigned OUT_BITS         = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BITS_PER_IN_WORD-1:0]      data_in [NUM_IN_WORDS],
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  input  logic                             data_in_last,
  output logic [OUT_BITS-1:0]              data_out,
  output logic [$clog2(ACC_BEATS+1)-1:0]   data_out_beats,
  output logic                             data_out_valid,
  input  logic                             data_out_ready
);

  localparam int unsigned Layers = $clog2(NUM_IN_WORDS);
  localparam int unsigned TreeW  = BITS_PER_IN_WORD + Layers;
  localparam int unsigned CntW   = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;
  localparam int unsigned BeatsW = $clog2(ACC_BEATS + 1);
  localparam int unsigned ExtW   = OUT_BITS - TreeW;
  localparam bit          SignExt = (SIGN_EXT != 0);

  if (NUM_IN_WORDS < 2) begin : g_chk_words
    $error("NUM_IN_WORDS must be at least 2");
  end
  if (ACC_BEATS < 1) begin : g_chk_beats
    $error("ACC_BEATS must be at least 1");
  end
  if (OUT_BITS < BITS_PER_IN_WORD + $clog2(NUM_IN_WORDS) + $clog2(ACC_BEATS)) begin : g_chk_out
    $error("OUT_BITS too narrow for the worst-case group sum");
  end

  logic              advance;
  logic              accept;
  logic              eff_last;
  logic [CntW-1:0]   cnt_q;
  logic [Layers-1:0] vld_q;
  logic [Layers-1:0] last_q;

  // Whole pipeline moves in lockstep; only a held output result can stall it.
  assign advance       = !data_out_valid || data_out_ready;
  assign data_in_ready = advance;
  assign accept        = data_in_valid && advance;
  assign eff_last      = data_in_last || (cnt_q == CntW'(ACC_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= eff_last ? '0 : cnt_q + CntW'(1);
    end
  end

  // Bit i of vld_q/last_q tags the contents of tree layer i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (advance) begin
      vld_q  <= (vld_q << 1) | Layers'(accept);
      last_q <= (last_q << 1) | Layers'(accept && eff_last);
    end
  end

  for (genvar i = 0; i < Layers; i++) begin : g_layer
    localparam int unsigned InW    = BITS_PER_IN_WORD + i;
    localparam int unsigned InCnt  = (NUM_IN_WORDS + (1 << i) - 1) >> i;
    localparam int unsigned OutCnt = (InCnt + 1) / 2;

    logic [InW-1:0] src   [InCnt];
    logic [InW:0]   sum_d [OutCnt];
    logic [InW:0]   sum_q [OutCnt];

    if (i == 0) begin : g_src
      assign src = data_in;
    end else begin : g_src
      for (genvar k = 0; k < InCnt; k++) begin : g_w
        assign src[k] = g_layer[i-1].sum_q[k];
      end
    end

    // Each word grows by one bit per layer; an unpaired last word is only widened.
    for (genvar k = 0; k < OutCnt; k++) begin : g_word
      if (2 * k + 1 < InCnt) begin : g_pair
        assign sum_d[k] = {SignExt & src[2*k][InW-1], src[2*k]}
                        + {SignExt & src[2*k+1][InW-1], src[2*k+1]};
      end else begin : g_pass
        assign sum_d[k] = {SignExt & src[2*k][InW-1], src[2*k]};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '{default: '0};
      end else if (advance) begin
        sum_q <= sum_d;
      end
    end
  end

  logic [TreeW-1:0]    tree_sum;
  logic [OUT_BITS-1:0] tree_ext;
  logic                tree_vld;
  logic                tree_last;

  assign tree_sum  = g_layer[Layers-1].sum_q[0];
  assign tree_vld  = vld_q[Layers-1];
  assign tree_last = last_q[Layers-1];

  if (ExtW == 0) begin : g_ext_none
    assign tree_ext = tree_sum;
  end else begin : g_ext
    assign tree_ext = {{ExtW{SignExt & tree_sum[TreeW-1]}}, tree_sum};
  end

  logic [OUT_BITS-1:0] acc_q;
  logic [OUT_BITS-1:0] acc_nxt;
  logic [BeatsW-1:0]   beats_q;
  logic [BeatsW-1:0]   beats_nxt;
  logic                first_q;

  assign acc_nxt   = (first_q ? '0 : acc_q) + tree_ext;
  assign beats_nxt = first_q ? BeatsW'(1) : beats_q + BeatsW'(1);

  // A load on the same advance as a handshake keeps data_out_valid high: no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q          <= '0;
      beats_q        <= '0;
      first_q        <= 1'b1;
      data_out       <= '0;
      data_out_beats <= '0;
      data_out_valid <= 1'b0;
    end else if (advance) begin
      data_out_valid <= tree_vld && tree_last;
      if (tree_vld) begin
        acc_q   <= acc_nxt;
        beats_q <= beats_nxt;
        first_q <= tree_last;
        if (tree_last) begin
          data_out       <= acc_nxt;
          data_out_beats <= beats_nxt;
        end
      end
    end
  end

endmodule
